sonar_sampler: RTL and testbench
================================

# sonar_sampler

Upstream producer of the `sensor_input`/`sensor_output` words consumed by the VGA controller. Drives three HC-SR04-style ultrasonic rangers round-robin: pulses each trigger, times its echo, and converts echo width to whole centimetres. Packs the three 7-bit distances into one 32-bit word and publishes it after every full sweep. Fields sit at [6:0], [13:7] and [20:14]; 0 means "no reading".

## Interface
Parameters:
- `TRIG_CYCLES`, 500: trigger high time in clocks (10 µs @ 50 MHz).
- `CYCLES_PER_CM`, 2900: echo clocks per centimetre (58 µs @ 50 MHz).
- `TIMEOUT_CYCLES`, 1_500_000: maximum wait for echo rise, and maximum echo high time (30 ms).
- `GAP_CYCLES`, 500_000: quiet time after each channel before the next trigger (10 ms).

Ports:
- `clock`  in  1  system clock, shared with the VGA controller's capture domain.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `echo`  in  3  raw echo lines, asynchronous; bit n belongs to channel n.
- `trig`  out  3  trigger lines; at most one bit high at any time.
- `sensor_word`  out  32  {11'b0, d2[6:0], d1[6:0], d0[6:0]}; holds its value between sweeps.
- `word_valid`  out  1  one-clock pulse in the cycle `sensor_word` takes a new value.
- `active_ch`  out  2  channel currently being serviced (0..2).

## Operation
- Each `echo` bit passes through a 2-FF synchroniser followed by rise/fall detection.
- FSM states and transitions:
  - IDLE: after reset, moves to TRIG on the next clock, with `active_ch` = 0.
  - TRIG: `trig[active_ch]` = 1 for exactly TRIG_CYCLES clocks, then WAIT_RISE.
  - WAIT_RISE: a synchronised rise moves to MEASURE. If TIMEOUT_CYCLES elapse first, the channel's shadow field is set to 0 and the FSM moves to GAP.
  - MEASURE: a prescaler counts 0..CYCLES_PER_CM-1. On each wrap, the cm counter increments, saturating at 127.
    - Synchronised fall: shadow field <= cm counter, then GAP.
    - Echo still high after TIMEOUT_CYCLES: shadow field <= 0, then GAP.
  - GAP: waits GAP_CYCLES. If `active_ch` = 2, the cycle leaving GAP copies the shadow register to `sensor_word` and pulses `word_valid`, and `active_ch` returns to 0. Otherwise `active_ch` increments. Next state is TRIG.
- Distance = floor(high_clocks / CYCLES_PER_CM), clamped to 127. An echo shorter than CYCLES_PER_CM reads 0.
- Echo edges on non-selected channels are ignored. An echo already high when WAIT_RISE is entered produces no rise, so it times out.
- Bits [31:21] of `sensor_word` are always 0.

## Timing
- Reset values: `trig` = 0, `sensor_word` = 0, `word_valid` = 0, `active_ch` = 0, shadow = 0, all counters = 0, FSM = IDLE.
- Asserting `reset` mid-operation drops `trig` in the same instant. No partial word is ever published.
- Synchroniser latency is 2 clocks, and the same latency applies to both edges, so measured width equals true width ±1 clock.
- `trig` rises exactly 1 clock after the FSM enters TRIG. It is registered with no combinational path to outputs.
- `sensor_word` and `word_valid` change on the same clock edge. `word_valid` is never high on two consecutive cycles.
- Sweep period = 3·(1 + TRIG_CYCLES + wait + echo + GAP_CYCLES) clocks, plus the synchroniser and state-transition overheads.
- A fall and the timeout in the same cycle: the fall wins and the measured value is stored.
- A prescaler wrap and the fall in the same cycle: the incremented count is stored.

## Structure
- Shared package `sonar_pkg`:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, GAP);
  - field LSB constants 0, 7, 14;
  - `DIST_W` = 7 and `DIST_MAX` = 127;
  - `NUM_CH` = 3.
- Sub-module `echo_sync`: 2-FF synchroniser plus rise/fall pulse outputs, instantiated once per channel.
- Counters are sized with `$clog2` of the larger of TIMEOUT_CYCLES and GAP_CYCLES. The prescaler is sized with `$clog2(CYCLES_PER_CM)`.

## Test plan
All scenarios use simulation parameters TRIG_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=2000, GAP_CYCLES=8.
- Echo widths of 250/500/1000 clocks on ch0/1/2 -> `sensor_word` = {11'b0, 7'd100, 7'd50, 7'd25}, `word_valid` pulses exactly once per sweep, `trig` bits are one-hot and each 4 clocks wide.
- Ch1 never echoes -> after 2000 clocks in WAIT_RISE, field [13:7] = 0 and ch0/ch2 fields are correct.
- Ch2 echo of 1500 clocks -> field [20:14] = 127 (saturated). Ch2 echo held high for more than 2000 clocks -> field = 0.
- Echo of 9 clocks -> field 0. Echo of 10 clocks -> field 1 (boundary, including the ±1 synchroniser tolerance check).
- Glitches on ch1/ch2 echo while ch0 is active -> no effect on ch0's value or on the FSM.
- `reset` asserted mid-MEASURE on ch1 -> `trig` = 0 immediately, `sensor_word` = 0, and the next published word reflects only post-reset sweeps.

Source files
------------

// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the three-channel ultrasonic
// ranger sampler.
//   state_e        FSM states of the round-robin sequencer
//   NUM_CH         number of ranger channels
//   DIST_W/MAX     width and saturation value of one distance field
//   FIELDn_LSB     bit position of channel n's field in the published word
//   ch_onehot()    channel index -> one-hot trigger vector
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_e;

  localparam int NUM_CH = 3;
  localparam int DIST_W = 7;
  localparam logic [DIST_W-1:0] DIST_MAX = 7'd127;

  localparam int FIELD0_LSB = 0;
  localparam int FIELD1_LSB = 7;
  localparam int FIELD2_LSB = 14;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NUM_CH-1:0] oh;
    for (int i = 0; i < NUM_CH; i++) oh[i] = (ch == 2'(i));
    return oh;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: brings one asynchronous echo line into the clock domain with a
// 2-FF synchroniser and produces single-cycle rise/fall pulses.
//   clock, reset  system clock, async active-high reset
//   echo_i        raw echo line
//   rise_o        one-clock pulse on a synchronised 0->1 transition
//   fall_o        one-clock pulse on a synchronised 1->0 transition
// Both edges see the same 2-clock latency, so widths are preserved.
module echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;  // s3_q is the previous synchronised level

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= echo_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/sonar_sampler.sv
// sonar_sampler: services three HC-SR04-style rangers round-robin. For each
// channel it pulses the trigger, waits for the echo, times its width in
// centimetre units and stores the result in a shadow register. After channel
// 2 the shadow is published as one word.
//   clock, reset  system clock, async active-high reset
//   echo[2:0]     raw asynchronous echo lines, bit n = channel n
//   trig[2:0]     trigger outputs, at most one high
//   sensor_word   {11'b0, d2, d1, d0}, held between sweeps
//   word_valid    one-clock pulse when sensor_word updates
//   active_ch     channel currently being serviced
module sonar_sampler
  import sonar_pkg::*;
#(
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trig,
  output logic [31:0]       sensor_word,
  output logic              word_valid,
  output logic [1:0]        active_ch
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int PRE_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  logic [NUM_CH-1:0] rise, fall;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    echo_sync u_sync (
      .clock  (clock),
      .reset  (reset),
      .echo_i (echo[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  state_e                         state_q;
  logic [1:0]                     ch_q;
  logic [CNT_W-1:0]               cnt_q;   // shared by trigger, timeout and gap timing
  logic [PRE_W-1:0]               pre_q;   // clocks within the current centimetre
  logic [DIST_W-1:0]              cm_q;
  logic [NUM_CH-1:0][DIST_W-1:0]  shadow_q;
  logic [31:0]                    word_q;
  logic                           valid_q;
  logic [NUM_CH-1:0]              trig_q;

  logic              wrap;
  logic [DIST_W-1:0] cm_inc;
  logic              rise_sel, fall_sel;
  logic [31:0]       word_d;

  always_comb begin
    wrap     = (pre_q == PRE_W'(CYCLES_PER_CM - 1));
    // Count including this cycle's wrap, so a fall coinciding with a wrap
    // stores the incremented value.
    cm_inc   = (wrap && cm_q != DIST_MAX) ? cm_q + 7'd1 : cm_q;
    // Only the serviced channel's edges matter; the rest are ignored.
    rise_sel = rise[ch_q];
    fall_sel = fall[ch_q];
    word_d   = '0;
    word_d[FIELD0_LSB +: DIST_W] = shadow_q[0];
    word_d[FIELD1_LSB +: DIST_W] = shadow_q[1];
    word_d[FIELD2_LSB +: DIST_W] = shadow_q[2];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      pre_q    <= '0;
      cm_q     <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      trig_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= TRIG;
          ch_q    <= '0;
          cnt_q   <= '0;
        end
        TRIG: begin
          // Trigger goes high one clock after entry and stays for
          // cnt_q = 1..TRIG_CYCLES.
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == '0) trig_q <= ch_onehot(ch_q);
          if (cnt_q == CNT_W'(TRIG_CYCLES)) begin
            trig_q  <= '0;
            cnt_q   <= '0;
            state_q <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (rise_sel) begin
            state_q <= MEASURE;
            cnt_q   <= '0;
            pre_q   <= '0;
            cm_q    <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            shadow_q[ch_q] <= '0;
            cnt_q          <= '0;
            state_q        <= GAP;
          end
        end
        MEASURE: begin
          // Every MEASURE cycle, including the fall cycle, is one echo clock.
          cnt_q <= cnt_q + CNT_W'(1);
          pre_q <= wrap ? '0 : pre_q + PRE_W'(1);
          cm_q  <= cm_inc;
          if (fall_sel) begin
            shadow_q[ch_q] <= cm_inc;
            cnt_q          <= '0;
            state_q        <= GAP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            shadow_q[ch_q] <= '0;
            cnt_q          <= '0;
            state_q        <= GAP;
          end
        end
        GAP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= TRIG;
            if (ch_q == 2'(NUM_CH - 1)) begin
              word_q  <= word_d;
              valid_q <= 1'b1;
              ch_q    <= '0;
            end else begin
              ch_q <= ch_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig        = trig_q;
  assign sensor_word = word_q;
  assign word_valid  = valid_q;
  assign active_ch   = ch_q;

endmodule

// File: tb/tb_sonar_sampler.sv
// tb_sonar_sampler: directed, table-driven bench for sonar_sampler with
// small parameters (trigger 4, 10 clocks/cm, timeout 2000, gap 8). A bench
// "sensor" answers each trigger with an echo of a tabled width; the
// published word is compared with hand-computed distances. Monitors check
// trigger width/one-hotness and word_valid pulse shape continuously.
module tb_sonar_sampler;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  echo;
  logic [2:0]  trig;
  logic [31:0] sensor_word;
  logic        word_valid;
  logic [1:0]  active_ch;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sonar_sampler #(
    .TRIG_CYCLES    (4),
    .CYCLES_PER_CM  (10),
    .TIMEOUT_CYCLES (2000),
    .GAP_CYCLES     (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .echo        (echo),
    .trig        (trig),
    .sensor_word (sensor_word),
    .word_valid  (word_valid),
    .active_ch   (active_ch)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- monitors ----
  int          pub_cnt = 0;
  logic [31:0] last_word = '0;
  logic        prev_v = 1'b0;
  int          run[3] = '{0, 0, 0};

  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0;
      for (int c = 0; c < 3; c++) run[c] = 0;
    end else begin
      if (word_valid) begin
        pub_cnt++;
        last_word = sensor_word;
        chk("valid_not_back_to_back", {31'b0, prev_v}, 32'd0);
      end
      prev_v = word_valid;
      if (trig != 3'b000) chk("trig_onehot", $countones(trig), 32'd1);
      for (int c = 0; c < 3; c++) begin
        if (trig[c]) run[c]++;
        else if (run[c] != 0) begin
          chk("trig_width", run[c], 32'd4);
          run[c] = 0;
        end
      end
    end
  end

  // ---- helpers ----
  task automatic wait_trig(input int ch, input logic lvl, output bit ok);
    int n;
    n = 0;
    while (trig[ch] !== lvl && n < 6000) begin
      @(negedge clock);
      n++;
    end
    ok = (trig[ch] === lvl);
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL trig_wait ch%0d: got %b expected %b (timed out)", ch, trig[ch], lvl);
    end
  endtask

  // One full sweep: answer each channel's trigger with an echo of width wN
  // (0 = no echo), optionally glitching the idle channels during ch0.
  task automatic run_sweep(input int w0, input int w1, input int w2,
                           input logic [6:0] e0, input logic [6:0] e1, input logic [6:0] e2,
                           input bit glitch, input string nm);
    int ws[3];
    int start;
    int n;
    bit ok;
    ws = '{w0, w1, w2};
    start = pub_cnt;
    for (int c = 0; c < 3; c++) begin
      wait_trig(c, 1'b1, ok);
      chk({nm, "_active_ch"}, {30'b0, active_ch}, c);
      wait_trig(c, 1'b0, ok);
      repeat (2) @(negedge clock);
      if (glitch && c == 0) begin
        echo[1] = 1'b1;
        repeat (2) @(negedge clock);
        echo[1] = 1'b0;
        echo[2] = 1'b1;
        @(negedge clock);
        echo[2] = 1'b0;
      end
      if (ws[c] > 0) begin
        echo[c] = 1'b1;
        for (int k = 0; k < ws[c]; k++) begin
          @(negedge clock);
          if (glitch && c == 0 && k == 5) echo[2] = 1'b1;
          if (glitch && c == 0 && k == 8) echo[2] = 1'b0;
        end
        echo[c] = 1'b0;
      end
      if (glitch && c == 0) chk({nm, "_glitch_ch"}, {30'b0, active_ch}, 32'd0);
    end
    n = 0;
    while (pub_cnt == start && n < 3000) begin
      @(posedge clock);
      n++;
    end
    chk({nm, "_word"}, last_word, {11'b0, e2, e1, e0});
    chk({nm, "_pub_count"}, pub_cnt - start, 32'd1);
  endtask

  typedef struct {
    int         w0, w1, w2;
    logic [6:0] d0, d1, d2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    vecs[0] = '{250, 500, 1000, 7'd25, 7'd50, 7'd100};  // nominal
    vecs[1] = '{250, 0,   1000, 7'd25, 7'd0,  7'd100};  // ch1 silent
    vecs[2] = '{9,   10,  1500, 7'd0,  7'd1,  7'd127};  // boundary + saturate
    vecs[3] = '{19,  11,  129,  7'd1,  7'd1,  7'd12};   // just-under-wrap widths
    vecs[4] = '{30,  40,  2100, 7'd3,  7'd4,  7'd0};    // ch2 held past timeout

    reset = 1'b1;
    echo  = 3'b000;
    repeat (3) @(negedge clock);
    chk("reset_trig", {29'b0, trig}, 32'd0);
    chk("reset_word", sensor_word, 32'd0);
    chk("reset_valid", {31'b0, word_valid}, 32'd0);
    chk("reset_active_ch", {30'b0, active_ch}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("trig_after_idle", {29'b0, trig}, 32'd0);
    @(negedge clock);
    chk("trig_first_rise", {29'b0, trig}, 32'd1);

    for (int i = 0; i < 5; i++)
      run_sweep(vecs[i].w0, vecs[i].w1, vecs[i].w2,
                vecs[i].d0, vecs[i].d1, vecs[i].d2, 1'b0, $sformatf("vec%0d", i));

    // Reset in the middle of ch1's measurement.
    wait_trig(1, 1'b1, ok);
    wait_trig(1, 1'b0, ok);
    repeat (2) @(negedge clock);
    echo[1] = 1'b1;
    repeat (30) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midreset_trig", {29'b0, trig}, 32'd0);
    chk("midreset_word", sensor_word, 32'd0);
    chk("midreset_active_ch", {30'b0, active_ch}, 32'd0);
    echo = 3'b000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run_sweep(55, 77, 123, 7'd5, 7'd7, 7'd12, 1'b0, "post_reset");

    // Glitches on idle channels during ch0.
    run_sweep(64, 45, 0, 7'd6, 7'd4, 7'd0, 1'b1, "glitch");

    // Reset while a trigger is high must drop it without a clock.
    wait_trig(0, 1'b1, ok);
    #2 reset = 1'b1;
    #1;
    chk("trig_async_drop", {29'b0, trig}, 32'd0);
    chk("trig_reset_word", sensor_word, 32'd0);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
